// File: rtl/ex_forwarding_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_forwarding_hazard_unit_pkg
// Brief    : Shared constants and helpers for the EX forwarding/hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package ex_forwarding_hazard_unit_pkg;

    localparam logic [1:0] c_FWD_REGFILE = 2'b00;
    localparam logic [1:0] c_FWD_WB      = 2'b01;
    localparam logic [1:0] c_FWD_MEM     = 2'b10;

    localparam logic [0:0] c_RUN   = 1'b0;
    localparam logic [0:0] c_STALL = 1'b1;

    // Shadow-stage flat layout: {dest, RegWrite, MemRead}, MemRead in bit 0.
    localparam int c_STAGE_CTRL_BITS = 2;
    localparam int c_ST_REGWRITE_IDX = 1;
    localparam int c_ST_MEMREAD_IDX  = 0;

    function automatic logic [1:0] fwdSelect(input logic uses,
                                             input logic hitEx,
                                             input logic hitMem);
        logic [1:0] sel;
        sel = c_FWD_REGFILE;
        if (uses) begin
            if (hitEx)
                sel = c_FWD_MEM;
            else if (hitMem)
                sel = c_FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_shadow_stage.sv
`default_nettype none
// ============================================================================
// Module   : hazard_shadow_stage
// Brief    : One resettable shadow-pipeline stage with bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_shadow_stage #(
    parameter int STAGE_BITS = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_bubble,
    input  logic [STAGE_BITS-1:0] i_stage,
    output logic [STAGE_BITS-1:0] o_stage
);

    logic [STAGE_BITS-1:0] r_stage;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stage <= '0;
        else if (i_bubble)
            r_stage <= '0;
        else
            r_stage <= i_stage;
    end

    assign o_stage = r_stage;

endmodule
`default_nettype wire

// File: rtl/ex_forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_forwarding_hazard_unit
// Brief    : EX-stage forwarding selects and load-use stall generation.
//            Optional stall counter enabled by macro HAZARD_STALL_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ex_forwarding_hazard_unit
    import ex_forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_BITS  = 5,
    parameter int STALL_CNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_BITS-1:0]  ID_Rs,
    input  logic [REG_ADDR_BITS-1:0]  ID_Rt,
    input  logic                      ID_UsesRs,
    input  logic                      ID_UsesRt,
    input  logic [REG_ADDR_BITS-1:0]  ID_WriteReg,
    input  logic                      ID_RegWrite,
    input  logic                      ID_MemRead,
    input  logic                      Flush,
    output logic [1:0]                ForwardA,
    output logic [1:0]                ForwardB,
`ifdef HAZARD_STALL_COUNT_EN
    output logic [STALL_CNT_BITS-1:0] StallCount,
`endif
    output logic                      Stall
);

    localparam int c_STAGE_BITS = REG_ADDR_BITS + c_STAGE_CTRL_BITS;

    logic [c_STAGE_BITS-1:0]  w_idStage;
    logic [c_STAGE_BITS-1:0]  w_exStage;
    logic [c_STAGE_BITS-1:0]  w_memStage;
    logic [c_STAGE_BITS-1:0]  w_wbStage;
    logic                     w_insertBubble;

    logic [REG_ADDR_BITS-1:0] w_exDest;
    logic                     w_exRegWrite;
    logic                     w_exMemRead;
    logic [REG_ADDR_BITS-1:0] w_memDest;
    logic                     w_memRegWrite;

    logic                     w_exFwdValid;
    logic                     w_memFwdValid;
    logic                     w_loadUse;

    logic [0:0]               r_state;
    logic [1:0]               r_forwardA;
    logic [1:0]               r_forwardB;

    assign w_idStage = {ID_WriteReg, ID_RegWrite, ID_MemRead};

    hazard_shadow_stage #(.STAGE_BITS(c_STAGE_BITS)) u_exStage (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_insertBubble),
        .i_stage  (w_idStage),
        .o_stage  (w_exStage)
    );

    hazard_shadow_stage #(.STAGE_BITS(c_STAGE_BITS)) u_memStage (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_stage  (w_exStage),
        .o_stage  (w_memStage)
    );

    hazard_shadow_stage #(.STAGE_BITS(c_STAGE_BITS)) u_wbStage (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_stage  (w_memStage),
        .o_stage  (w_wbStage)
    );

    assign w_exDest      = w_exStage[c_STAGE_BITS-1 -: REG_ADDR_BITS];
    assign w_exRegWrite  = w_exStage[c_ST_REGWRITE_IDX];
    assign w_exMemRead   = w_exStage[c_ST_MEMREAD_IDX];
    assign w_memDest     = w_memStage[c_STAGE_BITS-1 -: REG_ADDR_BITS];
    assign w_memRegWrite = w_memStage[c_ST_REGWRITE_IDX];

    // Register 0 is hard-wired, so a write to it is never a forwarding source.
    assign w_exFwdValid  = w_exRegWrite  && (w_exDest  != '0);
    assign w_memFwdValid = w_memRegWrite && (w_memDest != '0);

    assign w_loadUse = (r_state == c_RUN) && w_exMemRead && (w_exDest != '0) &&
                       ((ID_UsesRs && (ID_Rs == w_exDest)) ||
                        (ID_UsesRt && (ID_Rt == w_exDest)));

    assign Stall          = w_loadUse && !Flush;
    assign w_insertBubble = w_loadUse || Flush;

    // Selects are registered so they line up with the instruction in EX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_RUN;
            r_forwardA <= c_FWD_REGFILE;
            r_forwardB <= c_FWD_REGFILE;
        end else begin
            r_state <= Stall ? c_STALL : c_RUN;
            if (w_insertBubble) begin
                r_forwardA <= c_FWD_REGFILE;
                r_forwardB <= c_FWD_REGFILE;
            end else begin
                r_forwardA <= fwdSelect(ID_UsesRs,
                                        w_exFwdValid  && (w_exDest  == ID_Rs),
                                        w_memFwdValid && (w_memDest == ID_Rs));
                r_forwardB <= fwdSelect(ID_UsesRt,
                                        w_exFwdValid  && (w_exDest  == ID_Rt),
                                        w_memFwdValid && (w_memDest == ID_Rt));
            end
        end
    end

    assign ForwardA = r_forwardA;
    assign ForwardB = r_forwardB;

`ifdef HAZARD_STALL_COUNT_EN
    logic [STALL_CNT_BITS-1:0] r_stallCount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stallCount <= '0;
        else if (Stall && (r_stallCount != {STALL_CNT_BITS{1'b1}}))
            r_stallCount <= r_stallCount + {{(STALL_CNT_BITS-1){1'b0}}, 1'b1};
    end

    assign StallCount = r_stallCount;
`else
    logic w_unusedCfg;
    assign w_unusedCfg = (STALL_CNT_BITS > 0);
`endif

    // WB shadow is kept for pipeline fidelity; no decision reads it.
    logic w_unusedStages;
    assign w_unusedStages = ^{w_wbStage, w_memStage[c_ST_MEMREAD_IDX]};

endmodule
`default_nettype wire

// File: tb/tb_ex_forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_forwarding_hazard_unit
// Brief    : Directed self-checking bench with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_forwarding_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, ID_WriteReg = '0;
    logic       ID_UsesRs = 1'b0, ID_UsesRt = 1'b0;
    logic       ID_RegWrite = 1'b0, ID_MemRead = 1'b0, Flush = 1'b0;
    logic [1:0] ForwardA, ForwardB;
    logic       Stall;
`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] StallCount;
`endif

    ex_forwarding_hazard_unit #(.REG_ADDR_BITS(5), .STALL_CNT_BITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UsesRs   (ID_UsesRs),
        .ID_UsesRt   (ID_UsesRt),
        .ID_WriteReg (ID_WriteReg),
        .ID_RegWrite (ID_RegWrite),
        .ID_MemRead  (ID_MemRead),
        .Flush       (Flush),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
`ifdef HAZARD_STALL_COUNT_EN
        .StallCount  (StallCount),
`endif
        .Stall       (Stall)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 1'b0;
    logic lastStall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: which older instruction still in flight produces each operand.
    typedef struct { logic [4:0] dest; bit writes; bit load; } instr_t;
    instr_t inFlight[2];   // [0] one ahead (EX), [1] two ahead (MEM)
    bit     justStalled;
    logic [1:0] mFwdA, mFwdB;
    int     mStalls;

    function automatic bit modelStall();
        bit needs;
        needs = (ID_UsesRs && ID_Rs == inFlight[0].dest) || (ID_UsesRt && ID_Rt == inFlight[0].dest);
        return !justStalled && !Flush && inFlight[0].load && inFlight[0].dest != 0 && needs;
    endfunction

    function automatic logic [1:0] producerDistance(input logic [4:0] r, input logic uses);
        if (!uses || r == 0) return 2'd0;
        for (int d = 0; d < 2; d++)
            if (inFlight[d].writes && inFlight[d].dest == r)
                return (d == 0) ? 2'b10 : 2'b01;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            inFlight[0] = '{dest: 0, writes: 0, load: 0};
            inFlight[1] = '{dest: 0, writes: 0, load: 0};
            justStalled = 0; mFwdA = 0; mFwdB = 0; mStalls = 0;
        end else begin
            bit s;
            s = modelStall();
            if (s && mStalls < 65535) mStalls++;
            if (s || Flush) begin
                mFwdA = 0; mFwdB = 0;
            end else begin
                mFwdA = producerDistance(ID_Rs, ID_UsesRs);
                mFwdB = producerDistance(ID_Rt, ID_UsesRt);
            end
            inFlight[1] = inFlight[0];
            if (s || Flush) inFlight[0] = '{dest: 0, writes: 0, load: 0};
            else            inFlight[0] = '{dest: ID_WriteReg, writes: ID_RegWrite, load: ID_MemRead};
            justStalled = s;
        end
    end

    // Compare process: mid-cycle, inputs and outputs are both settled.
    always @(negedge clk) begin
        if (checkEn && reset) begin
            chk("cyc_ForwardA", {30'd0, ForwardA}, {30'd0, mFwdA});
            chk("cyc_ForwardB", {30'd0, ForwardB}, {30'd0, mFwdB});
            chk("cyc_Stall", {31'd0, Stall}, {31'd0, modelStall()});
`ifdef HAZARD_STALL_COUNT_EN
            chk("cyc_StallCount", {16'd0, StallCount}, mStalls);
`endif
        end
    end

    // Present one instruction in ID, capture Stall, and advance to just after the next edge.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic urs, input logic urt, input logic rw, input logic mr,
                         input logic fl);
        ID_Rs = rs; ID_Rt = rt; ID_WriteReg = wr;
        ID_UsesRs = urs; ID_UsesRt = urt; ID_RegWrite = rw; ID_MemRead = mr; Flush = fl;
        #1 lastStall = Stall;
        @(posedge clk); #2;
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_Stall", {31'd0, Stall}, 0);
        chk("rst_ForwardA", {30'd0, ForwardA}, 0);
        chk("rst_ForwardB", {30'd0, ForwardB}, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        checkEn = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5
        issue(1, 2, 3, 1, 1, 1, 0, 0);
        issue(3, 5, 4, 1, 1, 1, 0, 0);
        chk("exfwd_Stall", {31'd0, lastStall}, 0);
        chk("exfwd_A", {30'd0, ForwardA}, 2'b10);
        chk("exfwd_B", {30'd0, ForwardB}, 2'b00);
        repeat (3) nop();

        // add $3 ; nop ; or $6,$7,$3
        issue(1, 2, 3, 1, 1, 1, 0, 0);
        nop();
        issue(7, 3, 6, 1, 1, 1, 0, 0);
        chk("wbfwd_A", {30'd0, ForwardA}, 2'b00);
        chk("wbfwd_B", {30'd0, ForwardB}, 2'b01);
        repeat (3) nop();

        // lw $2,0($1) ; add $4,$2,$2 (held one cycle)
        issue(1, 0, 2, 1, 0, 1, 1, 0);
        issue(2, 2, 4, 1, 1, 1, 0, 0);
        chk("lu_Stall1", {31'd0, lastStall}, 1);
        chk("lu_bubbleA", {30'd0, ForwardA}, 2'b00);
        issue(2, 2, 4, 1, 1, 1, 0, 0);
        chk("lu_Stall2", {31'd0, lastStall}, 0);
        chk("lu_A", {30'd0, ForwardA}, 2'b01);
        chk("lu_B", {30'd0, ForwardB}, 2'b01);
        repeat (3) nop();

        // lw $2 ; add $4,$2,$5 flushed ; add re-fetched
        issue(1, 0, 2, 1, 0, 1, 1, 0);
        issue(2, 5, 4, 1, 1, 1, 0, 1);
        chk("fl_Stall", {31'd0, lastStall}, 0);
        chk("fl_A", {30'd0, ForwardA}, 2'b00);
        chk("fl_B", {30'd0, ForwardB}, 2'b00);
        issue(2, 5, 4, 1, 1, 1, 0, 0);
        chk("fl_after_Stall", {31'd0, lastStall}, 0);
        chk("fl_after_A", {30'd0, ForwardA}, 2'b01);
        repeat (3) nop();

        // addi $0,$1,5 ; add $6,$0,$0 ; lw $0 ; use $0
        issue(1, 0, 0, 1, 0, 1, 0, 0);
        issue(0, 0, 6, 1, 1, 1, 0, 0);
        chk("r0_A", {30'd0, ForwardA}, 2'b00);
        chk("r0_B", {30'd0, ForwardB}, 2'b00);
        issue(1, 0, 0, 1, 0, 1, 1, 0);
        issue(0, 0, 7, 1, 1, 1, 0, 0);
        chk("r0_load_Stall", {31'd0, lastStall}, 0);
        repeat (3) nop();

        // Double match (EX wins), Rs==Rt, unused operands
        issue(1, 2, 3, 1, 1, 1, 0, 0);
        issue(3, 3, 3, 1, 1, 1, 0, 0);
        chk("same_A", {30'd0, ForwardA}, 2'b10);
        chk("same_B", {30'd0, ForwardB}, 2'b10);
        issue(3, 1, 5, 1, 1, 1, 0, 0);
        chk("prio_A", {30'd0, ForwardA}, 2'b10);
        chk("prio_B", {30'd0, ForwardB}, 2'b00);
        issue(3, 5, 8, 0, 0, 1, 0, 0);
        chk("unused_A", {30'd0, ForwardA}, 2'b00);
        chk("unused_B", {30'd0, ForwardB}, 2'b00);
        repeat (3) nop();

        // Reset pulled mid-stall
        issue(0, 0, 1, 0, 0, 1, 0, 0);
        issue(1, 0, 2, 1, 0, 1, 1, 0);
        chk("mid_preA", {30'd0, ForwardA}, 2'b10);
        ID_Rs = 2; ID_Rt = 2; ID_WriteReg = 4; ID_UsesRs = 1; ID_UsesRt = 1;
        ID_RegWrite = 1; ID_MemRead = 0; Flush = 0;
        #1 chk("mid_preStall", {31'd0, Stall}, 1);
        reset = 1'b0;
        #1;
        chk("mid_Stall", {31'd0, Stall}, 0);
        chk("mid_A", {30'd0, ForwardA}, 0);
        chk("mid_B", {30'd0, ForwardB}, 0);
`ifdef HAZARD_STALL_COUNT_EN
        chk("mid_Count", {16'd0, StallCount}, 0);
`endif
        ID_Rs = 0; ID_Rt = 0; ID_WriteReg = 0; ID_UsesRs = 0; ID_UsesRt = 0; ID_RegWrite = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Three load-use pairs
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 2, 1, 0, 1, 1, 0);
            issue(2, 2, 4, 1, 1, 1, 0, 0);
            chk("pair_Stall", {31'd0, lastStall}, 1);
            issue(2, 2, 4, 1, 1, 1, 0, 0);
        end
        nop();
`ifdef HAZARD_STALL_COUNT_EN
        chk("pairs_Count", {16'd0, StallCount}, 3);
`endif
        repeat (2) nop();

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
